// File: rtl/owire_seq_if.sv
// Command/response bundle for the 1-Wire sequencer.
// Handshake: a command transfers on the rising clk edge where cmd_valid && cmd_ready; rsp_valid is a one-cycle pulse with no back-pressure.
interface owire_seq_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_data;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       presence;
  logic       busy;
  logic [2:0] fsm_state;

  modport master (
    output cmd_valid, cmd_op, cmd_data,
    input  cmd_ready, rsp_valid, rsp_data, presence, busy, fsm_state
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data,
    output cmd_ready, rsp_valid, rsp_data, presence, busy, fsm_state
  );
endinterface

// File: rtl/owire_seq.sv
// 1-Wire bus sequencer: reset/presence pulse, byte write and byte read, LSB first.
// dq is open-drain; the line is only ever pulled low, the external pull-up supplies the high level.
module owire_seq #(
  parameter int T_RST  = 480,
  parameter int T_PRES = 70,
  parameter int T_SLOT = 60,
  parameter int T_LOW1 = 6,
  parameter int T_SAMP = 15,
  parameter int T_REC  = 5
) (
  input  logic       clk,
  input  logic       rst,
  owire_seq_if.slave bus,
  inout  wire        dq
);

  localparam int CMAX = (T_RST > T_SLOT) ? T_RST : T_SLOT;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [1:0] OP_RST   = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RST_LOW  = 3'd1,
    RST_WAIT = 3'd2,
    SLOT_LOW = 3'd3,
    SLOT_REL = 3'd4,
    SLOT_REC = 3'd5,
    DONE     = 3'd6
  } state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [2:0]      idx, idx_n;
  logic            de, de_n;
  logic [1:0]      op, op_n;
  logic [7:0]      data, data_n;
  logic [7:0]      shreg, shreg_n;
  logic            pres_q, pres_n;
  logic            rsp_valid_q, rsp_valid_n;
  logic [7:0]      rsp_data_q, rsp_data_n;
  logic            rdy_q, rdy_n;
  logic            busy_q, busy_n;
  logic            sync1, sync2;
  logic            wr_zero;

  assign dq = de ? 1'b0 : 1'bz;

  // Sample points below are taken 2 cycles late to cancel the synchronizer delay.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= dq;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt         <= '0;
      idx         <= '0;
      de          <= 1'b0;
      op          <= 2'b00;
      data        <= 8'h00;
      shreg       <= 8'h00;
      pres_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 8'h00;
      rdy_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      cnt         <= cnt_n;
      idx         <= idx_n;
      de          <= de_n;
      op          <= op_n;
      data        <= data_n;
      shreg       <= shreg_n;
      pres_q      <= pres_n;
      rsp_valid_q <= rsp_valid_n;
      rsp_data_q  <= rsp_data_n;
      rdy_q       <= rdy_n;
      busy_q      <= busy_n;
    end
  end

  assign wr_zero = (op == OP_WRITE) && !data[idx];

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    idx_n       = idx;
    de_n        = de;
    op_n        = op;
    data_n      = data;
    shreg_n     = shreg;
    pres_n      = pres_q;
    rsp_data_n  = rsp_data_q;

    case (state)
      IDLE: begin
        if (bus.cmd_valid && rdy_q) begin
          op_n   = bus.cmd_op;
          data_n = bus.cmd_data;
          cnt_n  = '0;
          idx_n  = '0;
          case (bus.cmd_op)
            OP_RST: begin
              state_n = RST_LOW;
              de_n    = 1'b1;
            end
            OP_WRITE, OP_READ: begin
              state_n = SLOT_LOW;
              de_n    = 1'b1;
              shreg_n = 8'h00;
            end
            default: state_n = DONE;
          endcase
        end
      end

      RST_LOW: begin
        cnt_n = cnt + CW'(1);
        if (cnt == CW'(T_RST - 1)) begin
          de_n    = 1'b0;
          cnt_n   = '0;
          state_n = RST_WAIT;
        end
      end

      RST_WAIT: begin
        cnt_n = cnt + CW'(1);
        if (cnt == CW'(T_PRES + 2)) pres_n = !sync2;
        if (cnt == CW'(T_RST - 1)) begin
          cnt_n   = '0;
          state_n = DONE;
        end
      end

      // A write-0 holds the line for the whole slot and skips SLOT_REL.
      SLOT_LOW: begin
        cnt_n = cnt + CW'(1);
        if (wr_zero) begin
          if (cnt == CW'(T_SLOT - 1)) begin
            de_n    = 1'b0;
            cnt_n   = '0;
            state_n = SLOT_REC;
          end
        end else if (cnt == CW'(T_LOW1 - 1)) begin
          de_n    = 1'b0;
          state_n = SLOT_REL;
        end
      end

      // cnt keeps counting from slot start so the read sample point is slot-relative.
      SLOT_REL: begin
        cnt_n = cnt + CW'(1);
        if ((op == OP_READ) && (cnt == CW'(T_SAMP + 2))) shreg_n[idx] = sync2;
        if (cnt == CW'(T_SLOT - 1)) begin
          cnt_n   = '0;
          state_n = SLOT_REC;
        end
      end

      SLOT_REC: begin
        cnt_n = cnt + CW'(1);
        if (cnt == CW'(T_REC - 1)) begin
          cnt_n = '0;
          if (idx == 3'd7) begin
            state_n = DONE;
          end else begin
            idx_n   = idx + 3'd1;
            de_n    = 1'b1;
            state_n = SLOT_LOW;
          end
        end
      end

      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase

    // Response, ready and busy are registered from the next state so they line up with it.
    rsp_valid_n = (state_n == DONE);
    if ((state_n == DONE) && (op_n == OP_READ)) rsp_data_n = shreg_n;
    rdy_n  = (state_n == IDLE);
    busy_n = (state_n != IDLE);
  end

  assign bus.cmd_ready = rdy_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.presence  = pres_q;
  assign bus.busy      = busy_q;
  assign bus.fsm_state = state;

endmodule

// File: tb/tb_owire_seq.sv
// Directed bench for owire_seq: bus reset with/without presence, byte write/read, back-to-back and mid-op reset.
// Cycle k counts negedges after the accepting rising edge (k = 1 is the first cycle after acceptance).
module tb_owire_seq;

  logic clk;
  logic rst;
  logic mdl_pull;
  wire  dq;

  owire_seq_if bus ();

  pullup (dq);
  assign dq = mdl_pull ? 1'b0 : 1'bz;

  owire_seq #(
    .T_RST (48),
    .T_PRES(7),
    .T_SLOT(12),
    .T_LOW1(2),
    .T_SAMP(4),
    .T_REC (2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .dq (dq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int run_start [16];
  int run_len   [16];
  int nruns;
  logic busy_c1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Dq pull-down model: 1 = presence answer after reset release, 2 = read slots 1,3, 3 = read slots 0,7.
  function automatic logic model_pull(input int mode, input int k);
    int s;
    s = (k - 1) / 14;
    case (mode)
      1:       return (k >= 52) && (k <= 68);
      2:       return (k >= 1) && (((k - 1) % 14) < 12) && ((s == 1) || (s == 3));
      3:       return (k >= 1) && (((k - 1) % 14) < 12) && ((s == 0) || (s == 7));
      default: return 1'b0;
    endcase
  endfunction

  // Returns at the negedge of cycle 1 after acceptance.
  task automatic issue(input logic [1:0] op, input logic [7:0] data);
    int w;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_data  = data;
    w = 0;
    while (!bus.cmd_ready && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (!bus.cmd_ready) check("accept_timeout", 32'(w), 32'd0);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  // Runs one op, records dq low runs and returns the cycle of rsp_valid (-1 on timeout).
  task automatic run_op(input logic [1:0] op, input logic [7:0] data, input int mode,
                        output int done_cyc);
    logic prev_low;
    nruns    = 0;
    done_cyc = -1;
    prev_low = 1'b0;
    issue(op, data);
    busy_c1 = bus.busy;
    for (int k = 1; k <= 400; k++) begin
      if (dq === 1'b0) begin
        if (!prev_low && nruns < 16) begin
          run_start[nruns] = k;
          run_len[nruns]   = 1;
          nruns++;
        end else if (prev_low && nruns > 0) begin
          run_len[nruns-1]++;
        end
      end
      prev_low = (dq === 1'b0);
      if (bus.rsp_valid) begin
        done_cyc = k;
        break;
      end
      mdl_pull = model_pull(mode, k);
      @(negedge clk);
    end
    mdl_pull = 1'b0;
  endtask

  // Called at the negedge of the rsp_valid cycle.
  task automatic check_tail(input string tag);
    check({tag, "_busy_done"}, 32'(bus.busy), 32'd1);
    check({tag, "_rdy_done"}, 32'(bus.cmd_ready), 32'd0);
    @(negedge clk);
    check({tag, "_rdy_after"}, 32'(bus.cmd_ready), 32'd1);
    check({tag, "_busy_after"}, 32'(bus.busy), 32'd0);
    check({tag, "_rv_after"}, 32'(bus.rsp_valid), 32'd0);
  endtask

  initial begin
    int d;
    int early;
    int rsp_k;
    int w;
    int rv_seen;
    logic [7:0] a5_widths [8];
    a5_widths = '{8'd2, 8'd12, 8'd2, 8'd12, 8'd12, 8'd2, 8'd12, 8'd2};

    rst           = 1'b0;
    mdl_pull      = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    bus.cmd_data  = 8'h00;
    repeat (3) @(negedge clk);

    check("rst_rdy", 32'(bus.cmd_ready), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_rv", 32'(bus.rsp_valid), 32'd0);
    check("rst_rdata", 32'(bus.rsp_data), 32'h00);
    check("rst_pres", 32'(bus.presence), 32'd0);
    check("rst_dq", 32'(dq), 32'd1);
    check("rst_state", 32'(bus.fsm_state), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("rdy_first_clk", 32'(bus.cmd_ready), 32'd1);

    // Bus reset with a device answering.
    run_op(2'b00, 8'h00, 1, d);
    check("brst_done_cyc", 32'(d), 32'd97);
    check("brst_busy_c1", 32'(busy_c1), 32'd1);
    check("brst_low_start", 32'(run_start[0]), 32'd1);
    check("brst_low_len", 32'(run_len[0]), 32'd48);
    check("brst_presence", 32'(bus.presence), 32'd1);
    check_tail("brst");

    // Bus reset with nobody on the line.
    run_op(2'b00, 8'h00, 0, d);
    check("brst2_done_cyc", 32'(d), 32'd97);
    check("brst2_presence", 32'(bus.presence), 32'd0);
    check("brst2_nruns", 32'(nruns), 32'd1);
    check_tail("brst2");

    // Read with device pulling slots 1 and 3.
    run_op(2'b10, 8'h00, 2, d);
    check("rd1_done_cyc", 32'(d), 32'd113);
    check("rd1_data", 32'(bus.rsp_data), 32'hF5);
    check_tail("rd1");

    // Write 0xA5: slot start and low width per bit.
    run_op(2'b01, 8'hA5, 0, d);
    check("wr_done_cyc", 32'(d), 32'd113);
    check("wr_nruns", 32'(nruns), 32'd8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("wr_start%0d", i), 32'(run_start[i]), 32'(1 + 14 * i));
      check($sformatf("wr_width%0d", i), 32'(run_len[i]), 32'(a5_widths[i]));
    end
    check("wr_rdata_held", 32'(bus.rsp_data), 32'hF5);
    check_tail("wr");

    // Read with device pulling slots 0 and 7.
    run_op(2'b10, 8'h00, 3, d);
    check("rd2_done_cyc", 32'(d), 32'd113);
    check("rd2_data", 32'(bus.rsp_data), 32'h7E);
    check_tail("rd2");

    // No-op completes immediately and leaves rsp_data alone.
    run_op(2'b11, 8'hFF, 0, d);
    check("nop_done_cyc", 32'(d), 32'd1);
    check("nop_nruns", 32'(nruns), 32'd0);
    check("nop_rdata_held", 32'(bus.rsp_data), 32'h7E);
    check_tail("nop");

    // cmd_valid held high across a write.
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'b01;
    bus.cmd_data  = 8'h3C;
    check("b2b_rdy0", 32'(bus.cmd_ready), 32'd1);
    @(negedge clk);
    early = 0;
    rsp_k = -1;
    for (int k = 1; k <= 114; k++) begin
      if (k < 114 && bus.cmd_ready) early++;
      if (bus.rsp_valid) rsp_k = k;
      if (k < 114) @(negedge clk);
    end
    check("b2b_no_early_accept", 32'(early), 32'd0);
    check("b2b_rsp_cyc", 32'(rsp_k), 32'd113);
    check("b2b_rdy_next", 32'(bus.cmd_ready), 32'd1);
    check("b2b_dq_idle", 32'(dq), 32'd1);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    check("b2b_second_busy", 32'(bus.busy), 32'd1);
    w = 0;
    while (!bus.rsp_valid && w < 200) begin
      @(negedge clk);
      w++;
    end
    check("b2b_second_done", 32'(bus.rsp_valid), 32'd1);
    @(negedge clk);

    // Reset asserted in slot 3 of a write-0x00.
    issue(2'b01, 8'h00);
    repeat (47) @(negedge clk);
    check("abort_dq_low", 32'(dq), 32'd0);
    rst = 1'b0;
    #1;
    check("abort_dq_rel", 32'(dq), 32'd1);
    check("abort_state", 32'(bus.fsm_state), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    rv_seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.rsp_valid) rv_seen++;
    end
    rst = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.rsp_valid) rv_seen++;
    end
    check("abort_no_rv", 32'(rv_seen), 32'd0);
    check("abort_rdy", 32'(bus.cmd_ready), 32'd1);
    check("abort_dq_idle", 32'(dq), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
